// File: rtl/pxs_text_row_ctrl.sv
// ----------------------------------------------------------------------------
// pxs_text_row_ctrl
//
// Sequencer for the glyph-drawing stage. It owns a COLS-character text buffer
// that one requester fills through a valid/ready byte port. As the RGB stream
// scans the text row, it drives the glyph stage's character/pos_x/pos_y.
// The RGB stream is forwarded with a one-cycle delay so that the cell data and
// the stream stay aligned downstream. Everything runs in the px_clk domain.
//
// Optional feature macro: PXS_TEXT_CURSOR_EN
//   When defined, a blinking block cursor (8'h7F) is drawn at the write column.
//   It toggles every BLINK_FRAMES rising edges of VS.
//
// Ports:
//   px_clk     in   1        pixel clock, all state on the rising edge
//   rst        in   1        asynchronous active-high reset
//   RGBStr_i   in   26       [0] active, [1] VS, [2] HS, [12:3] YC,
//                            [22:13] XC, [25:23] RGB
//   RGBStr_o   out  26       RGBStr_i delayed by one cycle
//   wr_valid   in   1        requester has a byte
//   wr_data    in   8        printable code or control code
//                            (0C clear, 0D CR, 08 BS)
//   wr_ready   out  1        byte accepted when wr_valid && wr_ready
//   character  out  8        code of the cell under the current pixel
//   pos_x      out  10       X origin of that cell
//   pos_y      out  10       Y origin of the row
//   in_row     out  1        current pixel lies inside the text row
//   cursor     out  log2(COLS)  next write column
// ----------------------------------------------------------------------------
module pxs_text_row_ctrl #(
    parameter int         COLS         = 16,
    parameter logic [9:0] ORG_X        = 10'd64,
    parameter logic [9:0] ORG_Y        = 10'd32,
    parameter int         CW           = 8,
    parameter int         CH           = 8,
    parameter int         BLINK_FRAMES = 32
) (
    input  logic                      px_clk,
    input  logic                      rst,
    input  logic [25:0]               RGBStr_i,
    output logic [25:0]               RGBStr_o,
    input  logic                      wr_valid,
    input  logic [7:0]                wr_data,
    output logic                      wr_ready,
    output logic [7:0]                character,
    output logic [9:0]                pos_x,
    output logic [9:0]                pos_y,
    output logic                      in_row,
    output logic [$clog2(COLS)-1:0]   cursor
);

    localparam int COL_W = $clog2(COLS);
    localparam int CW_SH = $clog2(CW);

    localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

    // The row window is checked in 11 bits. A row that runs past X=1023 is
    // clipped rather than wrapped back to the left edge.
    localparam logic [10:0] X_LO = {1'b0, ORG_X};
    localparam logic [10:0] X_HI = X_LO + 11'(COLS * CW);
    localparam logic [10:0] Y_LO = {1'b0, ORG_Y};
    localparam logic [10:0] Y_HI = Y_LO + 11'(CH);

    localparam logic [7:0] CODE_SPACE = 8'h20;
    localparam logic [7:0] CODE_CLEAR = 8'h0C;
    localparam logic [7:0] CODE_CR    = 8'h0D;
    localparam logic [7:0] CODE_BS    = 8'h08;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [COL_W-1:0]     cursor_q, cursor_d;
    logic [COL_W-1:0]     clr_idx_q, clr_idx_d;
    logic                 wr_ready_q, wr_ready_d;

    logic                 mem_we;
    logic [COL_W-1:0]     mem_waddr;
    logic [7:0]           mem_wdata;

    logic [25:0]          rgb_q, rgb_d;
    logic [7:0]           character_q, character_d;
    logic [9:0]           pos_x_q, pos_x_d;
    logic [9:0]           pos_y_q, pos_y_d;
    logic                 in_row_q, in_row_d;

    logic [10:0]          scan_x;
    logic [10:0]          scan_y;
    logic                 scan_hit;
    logic [COL_W-1:0]     scan_col;

    // The text buffer powers up as blanks and is deliberately left out of
    // reset, so a reset in the middle of a clear keeps whatever was not yet
    // erased.
    logic [7:0] text_mem [COLS] = '{default: 8'h20};

    // Byte-port sequencing. In IDLE an accepted byte is interpreted as a
    // control code or as a printable character. CLEAR sweeps one cell per
    // cycle. While it runs, the port is closed and the cursor is left alone
    // until the final cell.
    always_comb begin
        state_d    = state_q;
        cursor_d   = cursor_q;
        clr_idx_d  = clr_idx_q;
        mem_we     = 1'b0;
        mem_waddr  = cursor_q;
        mem_wdata  = CODE_SPACE;

        case (state_q)
            IDLE: begin
                if (wr_valid && wr_ready_q) begin
                    case (wr_data)
                        CODE_CLEAR: begin
                            state_d   = CLEAR;
                            clr_idx_d = '0;
                        end
                        CODE_CR: begin
                            cursor_d = '0;
                        end
                        CODE_BS: begin
                            if (cursor_q != '0) begin
                                cursor_d  = cursor_q - COL_ONE;
                                mem_we    = 1'b1;
                                mem_waddr = cursor_q - COL_ONE;
                            end
                        end
                        default: begin
                            mem_we    = 1'b1;
                            mem_wdata = wr_data;
                            cursor_d  = cursor_q + COL_ONE;
                        end
                    endcase
                end
            end
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_idx_q;
                clr_idx_d = clr_idx_q + COL_ONE;
                if (clr_idx_q == COL_LAST) begin
                    state_d  = IDLE;
                    cursor_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        wr_ready_d = (state_d == IDLE);
    end

    // Control flops. wr_ready stays low during reset and rises on the first
    // clock edge after reset is released.
    always_ff @(posedge px_clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cursor_q   <= '0;
            clr_idx_q  <= '0;
            wr_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cursor_q   <= cursor_d;
            clr_idx_q  <= clr_idx_d;
            wr_ready_q <= wr_ready_d;
        end
    end

    // Buffer write port. The scan reads combinationally before this edge
    // commits, so a write and a scan of the same cell in one cycle give the
    // old byte to the scan.
    always_ff @(posedge px_clk) begin
        if (mem_we) begin
            text_mem[mem_waddr] <= mem_wdata;
        end
    end

`ifdef PXS_TEXT_CURSOR_EN
    // Cursor blink timing. It counts rising edges of VS, which is one per
    // frame, and flips the blink phase every BLINK_FRAMES frames.
    logic        vs_prev_q, vs_prev_d;
    logic [15:0] blink_cnt_q, blink_cnt_d;
    logic        blink_q, blink_d;

    always_comb begin
        vs_prev_d   = RGBStr_i[1];
        blink_cnt_d = blink_cnt_q;
        blink_d     = blink_q;
        if (RGBStr_i[1] && !vs_prev_q) begin
            if (blink_cnt_q == 16'(BLINK_FRAMES - 1)) begin
                blink_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge px_clk or posedge rst) begin
        if (rst) begin
            vs_prev_q   <= 1'b0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else begin
            vs_prev_q   <= vs_prev_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
        end
    end
`endif

    // Row hit test and cell lookup. The results are registered below, which
    // is why the RGB stream is also delayed by one cycle. On a miss the
    // character goes blank, but the cell position holds its last value.
    always_comb begin
        scan_x   = {1'b0, RGBStr_i[22:13]};
        scan_y   = {1'b0, RGBStr_i[12:3]};
        scan_hit = (scan_y >= Y_LO) && (scan_y < Y_HI) &&
                   (scan_x >= X_LO) && (scan_x < X_HI);
        scan_col = COL_W'((scan_x - X_LO) >> CW_SH);

        rgb_d       = RGBStr_i;
        character_d = CODE_SPACE;
        pos_x_d     = pos_x_q;
        pos_y_d     = pos_y_q;
        in_row_d    = scan_hit;

        if (scan_hit) begin
            character_d = text_mem[scan_col];
            pos_x_d     = ORG_X + (10'(scan_col) << CW_SH);
            pos_y_d     = ORG_Y;
`ifdef PXS_TEXT_CURSOR_EN
            if (blink_q && (scan_col == cursor_q)) begin
                character_d = 8'h7F;
            end
`endif
        end
    end

    // Scan-side output flops.
    always_ff @(posedge px_clk or posedge rst) begin
        if (rst) begin
            rgb_q       <= '0;
            character_q <= CODE_SPACE;
            pos_x_q     <= ORG_X;
            pos_y_q     <= ORG_Y;
            in_row_q    <= 1'b0;
        end else begin
            rgb_q       <= rgb_d;
            character_q <= character_d;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            in_row_q    <= in_row_d;
        end
    end

    assign RGBStr_o  = rgb_q;
    assign character = character_q;
    assign pos_x     = pos_x_q;
    assign pos_y     = pos_y_q;
    assign in_row    = in_row_q;
    assign cursor    = cursor_q;
    assign wr_ready  = wr_ready_q;

endmodule

// File: tb/tb_pxs_text_row_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pxs_text_row_ctrl
//
// Directed bench for pxs_text_row_ctrl with the default 16-column geometry:
// origin (64,32) and 8x8 cells. Expected values are hand-derived from the
// cell geometry and the byte sequences written. The cursor-blink scenario is
// only built when PXS_TEXT_CURSOR_EN is defined.
// ----------------------------------------------------------------------------
module tb_pxs_text_row_ctrl;

   logic        px_clk;
   logic        rst;
   logic [25:0] RGBStr_i;
   logic [25:0] RGBStr_o;
   logic        wr_valid;
   logic [7:0]  wr_data;
   logic        wr_ready;
   logic [7:0]  character;
   logic [9:0]  pos_x;
   logic [9:0]  pos_y;
   logic        in_row;
   logic [3:0]  cursor;

   int checks;
   int errors;
   logic [25:0] lastRgb;

   pxs_text_row_ctrl #(
      .COLS(16), .ORG_X(10'd64), .ORG_Y(10'd32), .CW(8), .CH(8), .BLINK_FRAMES(2)
   ) dut (
      .px_clk(px_clk), .rst(rst), .RGBStr_i(RGBStr_i), .RGBStr_o(RGBStr_o),
      .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
      .character(character), .pos_x(pos_x), .pos_y(pos_y),
      .in_row(in_row), .cursor(cursor)
   );

   // 10 ns pixel clock.
   initial px_clk = 1'b0;
   always #5 px_clk = ~px_clk;

   // The single comparison point. It counts every check and reports any
   // mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
      end
   endtask

   // Inputs change 1 ns after the rising edge, and outputs are read there
   // too, well away from the edge.
   task automatic tick();
      @(posedge px_clk);
      #1;
   endtask

   // Drives one pixel of the stream and advances one clock. The RGB and HS
   // bits are varied so that the forwarding path sees changing data.
   task automatic applyStimulus(input int x, input int y, input logic vs);
      logic [9:0] xv;
      logic [9:0] yv;
      xv = 10'(x);
      yv = 10'(y);
      RGBStr_i = {xv[2:0], xv, yv, xv[0], vs, 1'b1};
      lastRgb  = RGBStr_i;
      tick();
   endtask

   // Waits, with a bound, for the port to open and then hands over one byte.
   task automatic sendByte(input logic [7:0] b);
      int n;
      n = 0;
      while (!wr_ready && n < 100) begin
         tick();
         n++;
      end
      if (!wr_ready) checkOutput("ready_timeout", 32'(wr_ready), 32'd1);
      wr_valid = 1'b1;
      wr_data  = b;
      tick();
      wr_valid = 1'b0;
   endtask

   // Scans the middle of cell idx and compares the character returned.
   task automatic checkCell(input string tag, input int idx, input logic [7:0] expected);
      applyStimulus(64 + idx * 8 + 5, 36, 1'b0);
      checkOutput(tag, 32'(character), 32'(expected));
   endtask

   initial begin
      int low;
      checks   = 0;
      errors   = 0;
      rst      = 1'b1;
      wr_valid = 1'b0;
      wr_data  = 8'h00;
      RGBStr_i = '0;
      lastRgb  = '0;

      // Values held while reset is asserted.
      #1;
      checkOutput("rst_rgb", 32'(RGBStr_o), 32'd0);
      checkOutput("rst_char", 32'(character), 32'h20);
      checkOutput("rst_posx", 32'(pos_x), 32'd64);
      checkOutput("rst_posy", 32'(pos_y), 32'd32);
      checkOutput("rst_inrow", 32'(in_row), 32'd0);
      checkOutput("rst_cursor", 32'(cursor), 32'd0);
      checkOutput("rst_ready", 32'(wr_ready), 32'd0);
      tick();
      checkOutput("rst_ready_held", 32'(wr_ready), 32'd0);
      rst = 1'b0;
      tick();
      tick();
      checkOutput("ready_after_rst", 32'(wr_ready), 32'd1);

      // Idle scan of the whole row width. Every pixel is blank, inside the
      // row, and the stream is delayed by one cycle.
      for (int x = 64; x < 192; x++) begin
         applyStimulus(x, 32 + (x % 8), 1'b0);
         checkOutput("scan_char", 32'(character), 32'h20);
         checkOutput("scan_inrow", 32'(in_row), 32'd1);
         checkOutput("scan_posx", 32'(pos_x), 32'(64 + ((x - 64) / 8) * 8));
         checkOutput("scan_rgb", 32'(RGBStr_o), 32'(lastRgb));
      end

      // Row boundaries.
      applyStimulus(191, 39, 1'b0);
      checkOutput("edge_last_in", 32'(in_row), 32'd1);
      checkOutput("edge_last_posx", 32'(pos_x), 32'd184);
      applyStimulus(192, 35, 1'b0);
      checkOutput("edge_right_out", 32'(in_row), 32'd0);
      checkOutput("edge_hold_posx", 32'(pos_x), 32'd184);
      applyStimulus(63, 35, 1'b0);
      checkOutput("edge_left_out", 32'(in_row), 32'd0);
      applyStimulus(100, 40, 1'b0);
      checkOutput("edge_below_out", 32'(in_row), 32'd0);
      applyStimulus(100, 31, 1'b0);
      checkOutput("edge_above_out", 32'(in_row), 32'd0);
      checkOutput("edge_posy", 32'(pos_y), 32'd32);

      // Write "AB".
      sendByte(8'h41);
      sendByte(8'h42);
      checkOutput("ab_cursor", 32'(cursor), 32'd2);
      applyStimulus(72, 32, 1'b0);
      checkOutput("ab_char1", 32'(character), 32'h42);
      checkOutput("ab_posx1", 32'(pos_x), 32'd72);
      applyStimulus(64, 32, 1'b0);
      checkOutput("ab_char0", 32'(character), 32'h41);
      applyStimulus(10, 32, 1'b0);
      checkOutput("miss_char", 32'(character), 32'h20);
      checkOutput("miss_posx_hold", 32'(pos_x), 32'd64);

      // Backspace, then carriage return.
      sendByte(8'h08);
      checkOutput("bs_cursor", 32'(cursor), 32'd1);
      checkCell("bs_cell1", 1, 8'h20);
      checkCell("bs_cell0", 0, 8'h41);
      sendByte(8'h0D);
      checkOutput("cr_cursor", 32'(cursor), 32'd0);
      checkCell("cr_cell0", 0, 8'h41);

      // 17 printable bytes wrap the cursor, so the 17th byte overwrites cell 0.
      for (int i = 0; i < 17; i++) sendByte(8'(8'h61 + i));
      checkOutput("wrap_cursor", 32'(cursor), 32'd1);
      checkCell("wrap_cell0", 0, 8'h71);
      checkCell("wrap_cell1", 1, 8'h62);
      checkCell("wrap_cell15", 15, 8'h70);

      // Backspace from 1 blanks cell 0. A backspace at column 0 does nothing.
      sendByte(8'h08);
      checkOutput("bs0_cursor", 32'(cursor), 32'd0);
      checkCell("bs0_cell0", 0, 8'h20);
      sendByte(8'h08);
      checkOutput("bs_at0_cursor", 32'(cursor), 32'd0);
      checkCell("bs_at0_cell15", 15, 8'h70);

      // Clear with wr_valid held high. The port must stay closed for exactly
      // 16 cycles, and then the next byte is taken.
      sendByte(8'h58);
      sendByte(8'h59);
      sendByte(8'h5A);
      checkOutput("pre_clr_cursor", 32'(cursor), 32'd3);
      wr_valid = 1'b1;
      wr_data  = 8'h0C;
      tick();
      wr_data  = 8'h55;
      checkOutput("clr_cursor_hold", 32'(cursor), 32'd3);
      low = wr_ready ? 0 : 1;
      while (!wr_ready && low < 100) begin
         tick();
         if (!wr_ready) low++;
      end
      checkOutput("clr_ready_low", 32'(low), 32'd16);
      checkOutput("clr_cursor_end", 32'(cursor), 32'd0);
      tick();
      wr_valid = 1'b0;
      checkOutput("clr_next_cursor", 32'(cursor), 32'd1);
      checkCell("clr_next_cell0", 0, 8'h55);
      for (int i = 1; i < 16; i++) checkCell("clr_cell", i, 8'h20);

      // Reset during the sixth CLEAR cycle: cells 0..4 are already blank and
      // the rest keep their data.
      sendByte(8'h0D);
      for (int i = 0; i < 16; i++) sendByte(8'(8'h30 + i));
      checkOutput("fill_cursor", 32'(cursor), 32'd0);
      wr_valid = 1'b1;
      wr_data  = 8'h0C;
      tick();
      wr_valid = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      rst = 1'b1;
      #1;
      checkOutput("midclr_rst_ready", 32'(wr_ready), 32'd0);
      checkOutput("midclr_rst_cursor", 32'(cursor), 32'd0);
      tick();
      tick();
      rst = 1'b0;
      tick();
      tick();
      checkOutput("midclr_ready", 32'(wr_ready), 32'd1);
      checkOutput("midclr_cursor", 32'(cursor), 32'd0);
      for (int i = 0; i < 5; i++) checkCell("midclr_cleared", i, 8'h20);
      for (int i = 5; i < 16; i++) checkCell("midclr_kept", i, 8'(8'h30 + i));

`ifdef PXS_TEXT_CURSOR_EN
      // Cursor parked on column 3, which holds 'Z'. The blink phase flips
      // every 2 VS rising edges.
      sendByte(8'h0D);
      sendByte(8'h57);
      sendByte(8'h58);
      sendByte(8'h59);
      sendByte(8'h5A);
      sendByte(8'h0D);
      sendByte(8'h57);
      sendByte(8'h58);
      sendByte(8'h59);
      checkOutput("blink_cursor", 32'(cursor), 32'd3);
      checkCell("blink_off", 3, 8'h5A);
      for (int i = 0; i < 2; i++) begin
         applyStimulus(0, 0, 1'b1);
         applyStimulus(0, 0, 1'b0);
      end
      checkCell("blink_on", 3, 8'h7F);
      checkCell("blink_other", 2, 8'h59);
      for (int i = 0; i < 2; i++) begin
         applyStimulus(0, 0, 1'b1);
         applyStimulus(0, 0, 1'b0);
      end
      checkCell("blink_restore", 3, 8'h5A);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
